// File: rtl/sync_pkg.sv
// Shared helpers for the clock-domain-crossing blocks.
package sync_pkg;

  // Ceiling log2 with a floor of 1 so a counter never collapses to zero width.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/signal_sync_filter_chan.sv
// One channel: flop-chain synchroniser, stability filter and registered edge pulses.
module signal_sync_filter_chan
  import sync_pkg::*;
#(
  parameter int   Depth        = 2,
  parameter int   FilterCycles = 1,
  parameter logic ResetBit     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic sigout,
  output logic rise,
  output logic fall
);

  localparam int CntW = clog2(FilterCycles + 1);

  logic [Depth-1:0] r_sync;
  logic [CntW-1:0]  r_cnt;
  logic             r_sigout;
  logic             r_rise;
  logic             r_fall;
  logic             w_s;
  logic             w_differ;
  logic             w_accept;

  assign w_s      = r_sync[Depth-1];
  assign w_differ = (w_s != r_sigout);
  assign w_accept = w_differ && (r_cnt == CntW'(FilterCycles - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {Depth{ResetBit}};
    end else begin
      r_sync <= {r_sync[Depth-2:0], sig};
    end
  end

  // Any cycle where the synchronised value matches the output restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_sigout <= ResetBit;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_rise <= ~r_sigout & w_s & w_accept;
      r_fall <= r_sigout & ~w_s & w_accept;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_sigout <= w_s;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign sigout = r_sigout;
  assign rise   = r_rise;
  assign fall   = r_fall;

endmodule

// File: rtl/signal_sync_filter.sv
// Multi-channel synchroniser with glitch filter and edge detection; one independent channel per bit.
module signal_sync_filter
  import sync_pkg::*;
#(
  parameter int               Width        = 1,
  parameter int               Depth        = 2,
  parameter int               FilterCycles = 1,
  parameter logic [Width-1:0] ResetValue   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] sig,
  output logic [Width-1:0] sigout,
  output logic [Width-1:0] rise,
  output logic [Width-1:0] fall
);

  if (Depth < 2) begin : g_bad_depth
    $fatal(1, "signal_sync_filter: Depth must be at least 2");
  end
  if (FilterCycles < 1) begin : g_bad_filter
    $fatal(1, "signal_sync_filter: FilterCycles must be at least 1");
  end

  for (genvar i = 0; i < Width; i++) begin : g_chan
    signal_sync_filter_chan #(
      .Depth       (Depth),
      .FilterCycles(FilterCycles),
      .ResetBit    (ResetValue[i])
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .sig   (sig[i]),
      .sigout(sigout[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

// File: tb/tb_signal_sync_filter.sv
// Scoreboard bench: stimulus queues expected output by cycle, monitors compare on every falling edge.
module tb_signal_sync_filter;

  typedef struct {
    int         cyc;
    string      name;
    logic [3:0] sigout;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] sigA;
  logic [3:0] sigoutA;
  logic [3:0] riseA;
  logic [3:0] fallA;
  logic [1:0] sigB;
  logic [1:0] sigoutB;
  logic [1:0] riseB;
  logic [1:0] fallB;

  int   cyc = 0;
  int   nChecks = 0;
  int   nFails = 0;
  exp_t expA[$];
  exp_t expB[$];
  exp_t eA;
  exp_t eB;

  signal_sync_filter #(
    .Width(4), .Depth(2), .FilterCycles(4), .ResetValue(4'h0)
  ) dutA (
    .clk(clk), .rst_n(rst_n), .sig(sigA), .sigout(sigoutA), .rise(riseA), .fall(fallA)
  );

  signal_sync_filter #(
    .Width(2), .Depth(3), .FilterCycles(1), .ResetValue(2'b11)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .sig(sigB), .sigout(sigoutB), .rise(riseB), .fall(fallB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle-keyed expectations; any pulse on a cycle without an expectation is an error.
  always @(negedge clk) begin
    nChecks++;
    if (expA.size() > 0 && expA[0].cyc <= cyc) begin
      eA = expA.pop_front();
      if (eA.cyc != cyc || sigoutA !== eA.sigout || riseA !== eA.rise || fallA !== eA.fall) begin
        nFails++;
        $display("[TB] FAIL A.%s cyc=%0d(want %0d): got sigout=%h rise=%h fall=%h, want sigout=%h rise=%h fall=%h",
                 eA.name, cyc, eA.cyc, sigoutA, riseA, fallA, eA.sigout, eA.rise, eA.fall);
      end
    end else if ((riseA | fallA) !== 4'h0) begin
      nFails++;
      $display("[TB] FAIL A.unexpected_pulse cyc=%0d: got rise=%h fall=%h, want rise=0 fall=0",
               cyc, riseA, fallA);
    end
  end

  always @(negedge clk) begin
    nChecks++;
    if (expB.size() > 0 && expB[0].cyc <= cyc) begin
      eB = expB.pop_front();
      if (eB.cyc != cyc || {2'b00, sigoutB} !== eB.sigout || {2'b00, riseB} !== eB.rise ||
          {2'b00, fallB} !== eB.fall) begin
        nFails++;
        $display("[TB] FAIL B.%s cyc=%0d(want %0d): got sigout=%h rise=%h fall=%h, want sigout=%h rise=%h fall=%h",
                 eB.name, cyc, eB.cyc, sigoutB, riseB, fallB, eB.sigout, eB.rise, eB.fall);
      end
    end else if ((riseB | fallB) !== 2'b00) begin
      nFails++;
      $display("[TB] FAIL B.unexpected_pulse cyc=%0d: got rise=%h fall=%h, want rise=0 fall=0",
               cyc, riseB, fallB);
    end
  end

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic applyStimulus(input int atCyc, input logic [3:0] a, input logic [1:0] b);
    waitUntil(atCyc);
    sigA = a;
    sigB = b;
  endtask

  task automatic checkOutput(input bit isB, input int c, input string name,
                             input logic [3:0] so, input logic [3:0] r, input logic [3:0] f);
    exp_t e;
    e.cyc    = c;
    e.name   = name;
    e.sigout = so;
    e.rise   = r;
    e.fall   = f;
    if (isB) expB.push_back(e);
    else     expA.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    sigA  = 4'hF;
    sigB  = 2'b11;

    // Held in reset with inputs high; release at cycle 10 gives acceptance six edges later.
    for (int c = 2; c <= 10; c++) begin
      checkOutput(1'b0, c, "reset_hold", 4'h0, 4'h0, 4'h0);
    end
    checkOutput(1'b1, 5, "reset_b", 4'h3, 4'h0, 4'h0);
    checkOutput(1'b0, 15, "pre_accept", 4'h0, 4'h0, 4'h0);
    checkOutput(1'b0, 16, "release_rise", 4'hF, 4'hF, 4'h0);
    checkOutput(1'b0, 17, "rise_one_cycle", 4'hF, 4'h0, 4'h0);
    checkOutput(1'b1, 12, "b_after_reset", 4'h3, 4'h0, 4'h0);
    waitUntil(10);
    rst_n = 1'b1;

    applyStimulus(20, 4'h0, 2'b11);
    checkOutput(1'b0, 26, "all_fall", 4'h0, 4'h0, 4'hF);

    // Three-cycle glitch on channel 1 must be swallowed.
    applyStimulus(30, 4'h2, 2'b11);
    checkOutput(1'b0, 34, "glitch_mid", 4'h0, 4'h0, 4'h0);
    checkOutput(1'b0, 36, "glitch_after", 4'h0, 4'h0, 4'h0);
    applyStimulus(33, 4'h0, 2'b11);

    // Four-cycle pulse passes: rise at 46, fall at 50.
    applyStimulus(40, 4'h2, 2'b11);
    checkOutput(1'b0, 45, "pulse_pre", 4'h0, 4'h0, 4'h0);
    checkOutput(1'b0, 46, "pulse_rise", 4'h2, 4'h2, 4'h0);
    checkOutput(1'b0, 47, "pulse_high1", 4'h2, 4'h0, 4'h0);
    checkOutput(1'b0, 49, "pulse_high3", 4'h2, 4'h0, 4'h0);
    checkOutput(1'b0, 50, "pulse_fall", 4'h0, 4'h0, 4'h2);
    checkOutput(1'b0, 51, "pulse_low", 4'h0, 4'h0, 4'h0);
    applyStimulus(44, 4'h0, 2'b11);

    // Chatter 1,1,1,0,1,1,1,1: the zero restarts the count, acceptance at 70.
    checkOutput(1'b0, 66, "chatter_restart", 4'h0, 4'h0, 4'h0);
    checkOutput(1'b0, 69, "chatter_count", 4'h0, 4'h0, 4'h0);
    checkOutput(1'b0, 70, "chatter_rise", 4'h1, 4'h1, 4'h0);
    checkOutput(1'b0, 71, "chatter_settled", 4'h1, 4'h0, 4'h0);
    applyStimulus(60, 4'h1, 2'b11);
    applyStimulus(63, 4'h0, 2'b11);
    applyStimulus(64, 4'h1, 2'b11);

    applyStimulus(80, 4'h8, 2'b11);
    checkOutput(1'b0, 86, "swap_0_to_3", 4'h8, 4'h8, 4'h1);
    applyStimulus(90, 4'h4, 2'b11);
    checkOutput(1'b0, 96, "simultaneous", 4'h4, 4'h4, 4'h8);

    applyStimulus(100, 4'h0, 2'b11);
    checkOutput(1'b0, 106, "ch2_fall", 4'h0, 4'h0, 4'h4);

    // Channel 2 count reaches 3 at edge 115; reset there discards the pending value.
    applyStimulus(110, 4'h4, 2'b11);
    checkOutput(1'b0, 116, "midcount_reset", 4'h0, 4'h0, 4'h0);
    checkOutput(1'b0, 117, "midcount_held", 4'h0, 4'h0, 4'h0);
    checkOutput(1'b1, 117, "b_in_reset", 4'h3, 4'h0, 4'h0);
    checkOutput(1'b0, 122, "relatency_pre", 4'h0, 4'h0, 4'h0);
    checkOutput(1'b0, 123, "relatency_rise", 4'h4, 4'h4, 4'h0);
    checkOutput(1'b0, 124, "relatency_settled", 4'h4, 4'h0, 4'h0);
    waitUntil(115);
    rst_n = 1'b0;
    waitUntil(117);
    rst_n = 1'b1;

    // Alternate config: Depth 3, no filtering, reset level 1.
    checkOutput(1'b1, 120, "b_idle", 4'h3, 4'h0, 4'h0);
    checkOutput(1'b1, 133, "b_pre_fall", 4'h3, 4'h0, 4'h0);
    checkOutput(1'b1, 134, "b_fall", 4'h1, 4'h0, 4'h2);
    checkOutput(1'b1, 135, "b_after_fall", 4'h1, 4'h0, 4'h0);
    checkOutput(1'b1, 144, "b_swap", 4'h2, 4'h2, 4'h1);
    applyStimulus(130, 4'h4, 2'b01);
    applyStimulus(140, 4'h4, 2'b10);

    waitUntil(150);
    if (expA.size() != 0 || expB.size() != 0) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL leftover_expectations: got %0d/%0d pending, want 0/0",
               expA.size(), expB.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
